// File: rtl/pipe_pkg.sv
// Shared opcode, FSM state and forwarding-source encodings
// for the pipeline hazard control slice.
package pipe_pkg;

  localparam logic [1:0] OP_LI  = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_RSV = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_STALL = 2'b01;
  localparam logic [1:0] ST_REDIR = 2'b10;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EX = 2'b01;
  localparam logic [1:0] FWD_WB = 2'b10;

  function automatic logic op_we(
    input logic [1:0] op
  );
    return (op == OP_LI) || (op == OP_SLL);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage instruction fields in, stage enables,
// redirect, forwarding and status out.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 2,
  parameter int CNT_W  = 16
);
  logic              hold;
  logic              if_valid;
  logic [1:0]        id_opcode;
  logic [REG_AW-1:0] id_rd;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              pc_en;
  logic              if_id_en;
  logic              id_ex_en;
  logic              pc_sel;
  logic              flush_if_id;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              id_valid;
  logic              ex_valid;
  logic              wb_valid;
  logic              wb_we;
  logic [CNT_W-1:0]  retired;
  logic [1:0]        state;

  modport master (
    output hold, if_valid, id_opcode,
    output id_rd, id_rs1, id_rs2,
    input  pc_en, if_id_en, id_ex_en,
    input  pc_sel, flush_if_id,
    input  fwd_a, fwd_b,
    input  id_valid, ex_valid, wb_valid,
    input  wb_we, retired, state
  );

  modport slave (
    input  hold, if_valid, id_opcode,
    input  id_rd, id_rs1, id_rs2,
    output pc_en, if_id_en, id_ex_en,
    output pc_sel, flush_if_id,
    output fwd_a, fwd_b,
    output id_valid, ex_valid, wb_valid,
    output wb_we, retired, state
  );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Operand bypass select for one ID source register;
// the younger EX result wins over WB.
module fwd_sel
  import pipe_pkg::*;
#(
  parameter int REG_AW = 2
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] rs,
  input  logic              ex_valid,
  input  logic              ex_we,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              wb_valid,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  output logic [1:0]        sel
);

  logic hit_ex;
  logic hit_wb;

  assign hit_ex = id_valid & ex_valid
                & ex_we & (ex_rd == rs);
  assign hit_wb = id_valid & wb_valid
                & wb_we & (wb_rd == rs)
                & ~hit_ex;

  always_comb begin
    sel = FWD_RF;
    unique case (1'b1)
      hit_ex:  sel = FWD_EX;
      hit_wb:  sel = FWD_WB;
      default: sel = FWD_RF;
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/redirect FSM, stage tag pipeline, bypass
// selects and retired-instruction counter.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW = 2,
  parameter int CNT_W  = 16
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  logic              id_v;
  logic              ex_v;
  logic              ex_we;
  logic              ex_real;
  logic [REG_AW-1:0] ex_rd;
  logic              wb_v;
  logic              wb_we_t;
  logic              wb_real;
  logic [REG_AW-1:0] wb_rd;
  logic [CNT_W-1:0]  ret;
  logic [1:0]        st;
  logic [1:0]        st_nx;
  logic              frz;
  logic              jmp;
  logic              id_we;
  logic              id_real;

  assign frz     = bus.hold;
  assign jmp     = id_v & (bus.id_opcode == OP_J) & ~frz;
  assign id_we   = op_we(bus.id_opcode);
  assign id_real = (bus.id_opcode != OP_RSV);

  // A taken J squashes whatever IF fetched alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_v    <= 1'b0;
      ex_v    <= 1'b0;
      ex_we   <= 1'b0;
      ex_real <= 1'b0;
      ex_rd   <= '0;
      wb_v    <= 1'b0;
      wb_we_t <= 1'b0;
      wb_real <= 1'b0;
      wb_rd   <= '0;
      ret     <= '0;
    end else if (!frz) begin
      id_v    <= bus.if_valid & ~jmp;
      ex_v    <= id_v;
      ex_we   <= id_we;
      ex_real <= id_real;
      ex_rd   <= bus.id_rd;
      wb_v    <= ex_v;
      wb_we_t <= ex_we;
      wb_real <= ex_real;
      wb_rd   <= ex_rd;
      if (wb_v & wb_real)
        ret <= ret + CNT_W'(1);
    end
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      ST_RUN:
        st_nx = frz ? ST_STALL
              : (jmp ? ST_REDIR : ST_RUN);
      ST_REDIR:
        st_nx = frz ? ST_STALL : ST_RUN;
      ST_STALL:
        st_nx = frz ? ST_STALL : ST_RUN;
      default:
        st_nx = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= ST_RUN;
    else        st <= st_nx;
  end

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .id_valid (id_v),
    .rs       (bus.id_rs1),
    .ex_valid (ex_v),
    .ex_we    (ex_we),
    .ex_rd    (ex_rd),
    .wb_valid (wb_v),
    .wb_we    (wb_we_t),
    .wb_rd    (wb_rd),
    .sel      (bus.fwd_a)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .id_valid (id_v),
    .rs       (bus.id_rs2),
    .ex_valid (ex_v),
    .ex_we    (ex_we),
    .ex_rd    (ex_rd),
    .wb_valid (wb_v),
    .wb_we    (wb_we_t),
    .wb_rd    (wb_rd),
    .sel      (bus.fwd_b)
  );

  assign bus.pc_en       = ~frz;
  assign bus.if_id_en    = ~frz;
  assign bus.id_ex_en    = ~frz;
  assign bus.pc_sel      = jmp;
  assign bus.flush_if_id = jmp;
  assign bus.id_valid    = id_v;
  assign bus.ex_valid    = ex_v;
  assign bus.wb_valid    = wb_v;
  assign bus.wb_we       = wb_v & wb_we_t & ~frz;
  assign bus.retired     = ret;
  assign bus.state       = st;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: per-cycle instruction-level pipeline
// model plus hand-computed literal expectations.
module tb_pipe_hazard_ctrl;

  localparam int AW = 2;
  localparam int CW = 4;
  localparam int MODV = 1 << CW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit v;
    int op;
    int rd;
  } slot_t;

  bit    m_idv, n_idv;
  slot_t m_ex, m_wb, n_ex, n_wb;
  int    m_state, n_state;
  int    m_ret, n_ret;
  int    ret0;

  task automatic chk(input string name,
                     input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  function automatic bit writes(input slot_t s);
    return s.v && (s.op == 0 || s.op == 1);
  endfunction

  function automatic int fwd_exp(input int rs);
    if (!m_idv) return 0;
    if (writes(m_ex) && m_ex.rd == rs) return 1;
    if (writes(m_wb) && m_wb.rd == rs) return 2;
    return 0;
  endfunction

  task automatic model_clear();
    m_idv = 0;
    m_ex = '{0, 0, 0};
    m_wb = '{0, 0, 0};
    m_state = 0;
    m_ret = 0;
  endtask

  task automatic compare();
    bit jmp, h;
    int op, rd;
    h  = bus.hold;
    op = int'(bus.id_opcode);
    rd = int'(bus.id_rd);
    jmp = m_idv && op == 3 && !h;
    chk("state", int'(bus.state), m_state);
    chk("pc_en", int'(bus.pc_en), int'(!h));
    chk("if_id_en", int'(bus.if_id_en), int'(!h));
    chk("id_ex_en", int'(bus.id_ex_en), int'(!h));
    chk("pc_sel", int'(bus.pc_sel), int'(jmp));
    chk("flush", int'(bus.flush_if_id), int'(jmp));
    chk("fwd_a", int'(bus.fwd_a),
        fwd_exp(int'(bus.id_rs1)));
    chk("fwd_b", int'(bus.fwd_b),
        fwd_exp(int'(bus.id_rs2)));
    chk("id_valid", int'(bus.id_valid), int'(m_idv));
    chk("ex_valid", int'(bus.ex_valid), int'(m_ex.v));
    chk("wb_valid", int'(bus.wb_valid), int'(m_wb.v));
    chk("wb_we", int'(bus.wb_we),
        int'(writes(m_wb) && !h));
    chk("retired", int'(bus.retired), m_ret);
    if (h) n_state = 1;
    else if (m_state == 0 && jmp) n_state = 2;
    else n_state = 0;
    n_idv = m_idv; n_ex = m_ex;
    n_wb = m_wb; n_ret = m_ret;
    if (!h) begin
      if (m_wb.v && m_wb.op != 2)
        n_ret = (m_ret + 1) % MODV;
      n_wb = m_ex;
      n_ex = '{m_idv, op, rd};
      n_idv = bus.if_valid && !jmp;
    end
  endtask

  // Called just after a rising edge; returns at the falling edge.
  task automatic drive(input bit h, input bit ifv,
                       input int op, input int rd,
                       input int rs1, input int rs2);
    bus.hold = h;
    bus.if_valid = ifv;
    bus.id_opcode = op[1:0];
    bus.id_rd = rd[AW-1:0];
    bus.id_rs1 = rs1[AW-1:0];
    bus.id_rs2 = rs2[AW-1:0];
    @(negedge clk);
    compare();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    m_idv = n_idv; m_ex = n_ex; m_wb = n_wb;
    m_state = n_state; m_ret = n_ret;
  endtask

  task automatic step(input bit h, input bit ifv,
                      input int op, input int rd,
                      input int rs1, input int rs2);
    drive(h, ifv, op, rd, rs1, rs2);
    advance();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_state", int'(bus.state), 0);
    chk("rst_retired", int'(bus.retired), 0);
    chk("rst_pc_sel", int'(bus.pc_sel), 0);
    chk("rst_flush", int'(bus.flush_if_id), 0);
    chk("rst_fwd_a", int'(bus.fwd_a), 0);
    chk("rst_fwd_b", int'(bus.fwd_b), 0);
    chk("rst_wb_we", int'(bus.wb_we), 0);
    chk("rst_valids", int'({bus.id_valid,
        bus.ex_valid, bus.wb_valid}), 0);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.hold = 0; bus.if_valid = 0;
    bus.id_opcode = 0; bus.id_rd = 0;
    bus.id_rs1 = 0; bus.id_rs2 = 0;
    model_clear();

    // reset release, fill to WB
    do_reset();
    drive(0, 1, 0, 0, 0, 0);
    chk("lit_run", int'(bus.state), 0);
    chk("lit_en", int'({bus.pc_en, bus.if_id_en,
        bus.id_ex_en}), 7);
    chk("lit_ret0", int'(bus.retired), 0);
    advance();
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    chk("lit_wb_fill", int'(bus.wb_valid), 1);
    advance();

    // bypass: LI r1; SLL r2,r1,r1; LI r1; NOP; SLL r3,r1,r2
    do_reset();
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    drive(0, 1, 1, 2, 1, 1);
    chk("lit_fwd_ex_a", int'(bus.fwd_a), 1);
    chk("lit_fwd_ex_b", int'(bus.fwd_b), 1);
    advance();
    step(0, 1, 0, 1, 0, 0);
    step(0, 1, 2, 1, 1, 1);
    drive(0, 1, 1, 3, 1, 2);
    chk("lit_fwd_wb_a", int'(bus.fwd_a), 2);
    chk("lit_fwd_wb_b", int'(bus.fwd_b), 0);
    advance();
    step(0, 0, 0, 0, 0, 0);

    // jump redirect and wrong-path squash
    do_reset();
    step(0, 1, 0, 0, 0, 0);
    drive(0, 1, 3, 0, 0, 0);
    chk("lit_j_sel", int'(bus.pc_sel), 1);
    chk("lit_j_flush", int'(bus.flush_if_id), 1);
    advance();
    drive(0, 1, 0, 3, 0, 0);
    chk("lit_redir", int'(bus.state), 2);
    chk("lit_j_once", int'(bus.pc_sel), 0);
    chk("lit_bubble_id", int'(bus.id_valid), 0);
    advance();
    drive(0, 0, 0, 3, 0, 0);
    chk("lit_redir_end", int'(bus.state), 0);
    chk("lit_bubble_ex", int'(bus.ex_valid), 0);
    advance();
    drive(0, 0, 0, 0, 0, 0);
    chk("lit_bubble_wb", int'(bus.wb_valid), 0);
    chk("lit_j_ret", int'(bus.retired), 1);
    advance();

    // hold over a J in ID
    do_reset();
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    step(0, 1, 0, 2, 0, 0);
    drive(1, 1, 3, 0, 0, 0);
    ret0 = int'(bus.retired);
    chk("lit_hold_sel", int'(bus.pc_sel), 0);
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 3, 0, 0, 0);
      chk("lit_hold_st", int'(bus.state), 1);
      chk("lit_hold_ret", int'(bus.retired), ret0);
      chk("lit_hold_en", int'(bus.pc_en), 0);
      advance();
    end
    drive(0, 1, 3, 0, 0, 0);
    chk("lit_hold_fire", int'(bus.pc_sel), 1);
    advance();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // LI, NOP, SLL, J, (squash), LI
    do_reset();
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    step(0, 1, 2, 2, 0, 0);
    step(0, 1, 1, 3, 1, 1);
    drive(0, 1, 3, 0, 0, 0);
    chk("lit_nop_we", int'(bus.wb_we), 0);
    chk("lit_nop_wbv", int'(bus.wb_valid), 1);
    advance();
    step(0, 1, 0, 2, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++)
      step(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("lit_ret4", int'(bus.retired), 4);
    advance();
    step(0, 0, 0, 0, 0, 0);

    // counter wrap at 2^CNT_W
    do_reset();
    for (int i = 0; i < 16; i++)
      step(0, 1, 0, i % 4, 0, 0);
    for (int i = 16; i < 18; i++)
      step(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("lit_ret15", int'(bus.retired), 15);
    advance();
    drive(0, 0, 0, 0, 0, 0);
    chk("lit_wrap", int'(bus.retired), 0);
    advance();

    // reset while stalled
    step(0, 1, 0, 1, 0, 0);
    step(1, 1, 0, 1, 0, 0);
    step(1, 1, 0, 1, 0, 0);
    do_reset();
    chk("lit_rst_stall_en", int'(bus.pc_en), 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("lit_rst_run", int'(bus.state), 0);
    chk("lit_rst_en", int'(bus.id_ex_en), 1);
    advance();
    step(0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 2, register-address width (4 architectural registers).
REQ-002 SHALL have parameter CNT_W, default 16, retired-instruction counter width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port hold, input, 1, external freeze request.
REQ-006 SHALL have port if_valid, input, 1, fetch stage holds a real instruction.
REQ-007 SHALL have port id_opcode, input, 2, opcode of instruction in ID (00 LI, 01 SLL, 11 J, 10 reserved).
REQ-008 SHALL have ports id_rd, id_rs1 and id_rs2, input, REG_AW each, ID destination and sources.
REQ-009 SHALL have ports pc_en, if_id_en and id_ex_en, output, 1 each, stage-register enables.
REQ-010 SHALL have port pc_sel, output, 1, selects jump target for next PC.
REQ-011 SHALL have port flush_if_id, output, 1, replaces IF/ID contents with a bubble.
REQ-012 SHALL have ports fwd_a and fwd_b, output, 2 each, operand source: 00 regfile, 01 EX result, 10 WB result.
REQ-013 SHALL have ports id_valid, ex_valid and wb_valid, output, 1 each, stage occupancy.
REQ-014 SHALL have port wb_we, output, 1, register-file write enable for WB.
REQ-015 SHALL have port retired, output, CNT_W, count of LI/SLL/J instructions that left WB.
REQ-016 SHALL have port state, output, 2, FSM state (00 RUN, 01 STALL, 10 REDIRECT).

Function
REQ-017 SHALL keep internal per-stage tags {valid, we, rd, is_real} for ID, EX and WB; we = 1 only for LI and SLL; is_real = 0 for opcode 10.
REQ-018 SHALL, when not frozen, shift tags IF->ID->EX->WB each cycle, loading ID valid from if_valid.
REQ-019 SHALL compute jmp = id_valid & (id_opcode==11) & ~hold, combinationally.
REQ-020 SHALL drive pc_sel = jmp and flush_if_id = jmp in the same cycle; the next ID tag is then invalid.
REQ-021 SHALL have FSM states RUN, STALL and REDIRECT: RUN->STALL on hold; RUN->REDIRECT on jmp; REDIRECT->RUN after one cycle unless hold (->STALL); STALL->RUN on ~hold.
REQ-022 SHALL, in STALL, drive pc_en = if_id_en = id_ex_en = 0, hold all tags, and keep the retired count unchanged.
REQ-023 SHALL give hold priority over jmp; a J held in ID fires on the first cycle hold is low.
REQ-024 SHALL drive fwd_a = 01 when ex_valid & ex_we & ex_rd==id_rs1, else 10 when wb_valid & wb_we & wb_rd==id_rs1, else 00; fwd_b is computed identically from id_rs2; EX has priority over WB.
REQ-025 SHALL drive fwd_a = fwd_b = 00 when id_valid = 0.
REQ-026 SHALL drive wb_we = wb_valid & wb tag we & ~hold.
REQ-027 SHALL increment retired by 1 each non-frozen cycle in which wb_valid & is_real; it wraps modulo 2^CNT_W.
REQ-028 SHALL treat opcode 10 as a NOP: it flows through the stages with we = 0, no forwarding and no count.

Reset
REQ-029 SHALL, while rst_n is low, asynchronously force all tags invalid, state = RUN, retired = 0, pc_sel = flush_if_id = 0, fwd_a = fwd_b = 00, and wb_we = 0.
REQ-030 SHALL drive pc_en = if_id_en = id_ex_en = 1 after reset when hold is low; a reset during REDIRECT or STALL discards the pending state.

Structure
REQ-031 SHALL place the opcode localparams (LI, SLL, J, RSV), the state encodings and the fwd encodings in shared package pipe_pkg, also used by the control unit.
REQ-032 SHALL implement forwarding comparison in one sub-module fwd_sel, instantiated twice (operand a and operand b).

Verification
REQ-033 SHALL verify: reset released with hold = 0 and if_valid = 1 -> state = RUN, enables = 1, retired = 0, and after 3 cycles wb_valid = 1.
REQ-034 SHALL verify: LI r1 then SLL r2,r1,r1 back-to-back -> fwd_a = fwd_b = 01 while SLL is in ID; for LI r1, NOP, SLL r1 -> fwd_a = 10.
REQ-035 SHALL verify: J in ID -> pc_sel = flush_if_id = 1 for exactly one cycle, state = REDIRECT for one cycle, and the wrong-path instruction never reaches WB.
REQ-036 SHALL verify: hold = 1 for 4 cycles during a J in ID -> pc_sel = 0 throughout, the J fires on the first cycle after hold drops, and retired is unchanged during the hold.
REQ-037 SHALL verify: 5 instructions LI, 10, SLL, J, LI through the pipe -> retired = 4 and no wb_we for the opcode-10 slot.
REQ-038 SHALL verify: preload retired = 2^CNT_W-1 (CNT_W = 4, so 15), retire one instruction -> retired = 0.
